// File: rtl/dvsd_cmp_pkg.sv
// dvsd_cmp_pkg: shared state encoding, result bundle and width constant
// for the shared dvsd_cmp comparator arbiter.
package dvsd_cmp_pkg;

    localparam int DVSD_CMP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    function automatic logic is_onehot3(input cmp_res_t r);
        logic [2:0] v;
        v = {r.lt, r.eq, r.gt};
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

endpackage

// File: rtl/dvsd_rr_arbiter.sv
// dvsd_rr_arbiter: combinational round-robin pick, searching from
// i_ptr+1 upward with wrap; returns one-hot grant and its index.
module dvsd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    logic [ID_W-1:0] w_k;
    logic            w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_k = ID_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
            end
        end
    end

endmodule

// File: rtl/dvsd_cmp_arbiter.sv
// dvsd_cmp_arbiter: shares one dvsd_cmp between NUM_REQ requesters.
// Optional one-hot verdict checker enabled by CMP_ONEHOT_CHECK_EN.
module dvsd_cmp_arbiter
    import dvsd_cmp_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DVSD_CMP_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         cmp_a,
    output logic [DATA_W-1:0]         cmp_b,
    input  logic                      cmp_lt,
    input  logic                      cmp_eq,
    input  logic                      cmp_gt,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_lt,
    output logic                      resp_eq,
    output logic                      resp_gt,
    output logic                      cmp_err
);

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    cmp_res_t          r_res;
    logic              r_valid;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_xfer;
    cmp_res_t           w_cmp;
    logic [DATA_W-1:0]  w_a_arr [NUM_REQ];
    logic [DATA_W-1:0]  w_b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_a_arr[i] = req_a[i*DATA_W +: DATA_W];
        assign w_b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end

    dvsd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_cmp     = {cmp_lt, cmp_eq, cmp_gt};
    assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign w_xfer    = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= ID_W'(NUM_REQ - 1);
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_a     <= w_a_arr[w_idx];
                        r_b     <= w_b_arr[w_idx];
                        r_id    <= w_idx;
                        r_ptr   <= w_idx;
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_res   <= w_cmp;
                    r_valid <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmp_a      = r_a;
    assign cmp_b      = r_b;
    assign resp_valid = r_valid;
    assign resp_id    = r_id;
    assign resp_lt    = r_res.lt;
    assign resp_eq    = r_res.eq;
    assign resp_gt    = r_res.gt;

`ifdef CMP_ONEHOT_CHECK_EN
    logic r_err;

    // Sticky: a bad verdict flags the comparator until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == ST_EVAL && !is_onehot3(w_cmp)) begin
            r_err <= 1'b1;
        end
    end

    assign cmp_err = r_err;
`else
    assign cmp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dvsd_cmp_arbiter.sv
// tb_dvsd_cmp_arbiter: scoreboard bench with a round-robin reference
// model and a behavioural dvsd_cmp with a fault-injection switch.
module tb_dvsd_cmp_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   cmp_a;
    logic [W-1:0]   cmp_b;
    logic           cmp_lt;
    logic           cmp_eq;
    logic           cmp_gt;
    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic           resp_lt;
    logic           resp_eq;
    logic           resp_gt;
    logic           cmp_err;
    logic           fault = 1'b0;

    dvsd_cmp_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_lt     (cmp_lt),
        .cmp_eq     (cmp_eq),
        .cmp_gt     (cmp_gt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_lt    (resp_lt),
        .resp_eq    (resp_eq),
        .resp_gt    (resp_gt),
        .cmp_err    (cmp_err)
    );

    always #5 clk = ~clk;

    // Behavioural comparator; fault drives an illegal lt=gt=1 verdict.
    assign cmp_lt = fault ? 1'b1 : (cmp_a < cmp_b);
    assign cmp_eq = fault ? 1'b0 : (cmp_a == cmp_b);
    assign cmp_gt = fault ? 1'b1 : (cmp_a > cmp_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int a;
        int b;
        int lt;
        int eq;
        int gt;
        int t;
        bit f;
    } exp_t;

    exp_t q[$];
    int   ord[$];
    bit   free = 1'b1;
    int   free_at = 0;
    bit   err_exp = 1'b0;
    int   tests = 0;
    int   fails = 0;

    bit   v [N];
    int   a [N];
    int   b [N];
    bit   rr = 1'b1;
    bit   last_acc = 1'b0;
    int   last_g = 0;

    exp_t cur;
    bit   holding = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = v[i];
            req_a[i*W +: W]    = W'(a[i]);
            req_b[i*W +: W]    = W'(b[i]);
        end
        resp_ready = rr;
    endtask

    // One cycle: drive at negedge+2, predict the grant, check req_ready.
    task automatic step();
        int           g;
        int           x;
        logic [N-1:0] er;
        exp_t         e;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        apply();
        er       = '0;
        g        = -1;
        last_acc = 1'b0;
        if (free && cyc >= free_at) begin
            foreach (ord[k]) begin
                if (g < 0 && v[ord[k]]) g = ord[k];
            end
            if (g >= 0) begin
                e.id = g;
                e.a  = a[g];
                e.b  = b[g];
                e.f  = fault;
                e.lt = fault ? 1 : int'(a[g] < b[g]);
                e.eq = fault ? 0 : int'(a[g] == b[g]);
                e.gt = fault ? 1 : int'(a[g] > b[g]);
                e.t  = cyc + 2;
                q.push_back(e);
                er[g]    = 1'b1;
                free     = 1'b0;
                last_acc = 1'b1;
                last_g   = g;
                do begin
                    x = ord.pop_front();
                    ord.push_back(x);
                end while (x != g);
            end
        end
        #1;
        check("req_ready", 32'(req_ready), 32'(er));
    endtask

    task automatic step_drop();
        step();
        if (last_acc) v[last_g] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        apply();
        q.delete();
        ord      = '{0, 1, 2, 3};
        free     = 1'b1;
        free_at  = 0;
        err_exp  = 1'b0;
        last_acc = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        rr = 1'b1;
        repeat (n) step();
    endtask

    // Monitor: samples at negedge+3, after the driver has settled inputs.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (resp_valid === 1'b1) begin
                if (!holding) begin
                    check("resp_pending", 32'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        check("resp_latency", cyc, cur.t);
`ifdef CMP_ONEHOT_CHECK_EN
                        if (cur.f) err_exp = 1'b1;
`endif
                    end
                end
                check("resp_id", 32'(resp_id), cur.id);
                check("resp_lt", 32'(resp_lt), cur.lt);
                check("resp_eq", 32'(resp_eq), cur.eq);
                check("resp_gt", 32'(resp_gt), cur.gt);
                check("cmp_a", 32'(cmp_a), cur.a);
                check("cmp_b", 32'(cmp_b), cur.b);
                check("cmp_err", 32'(cmp_err), 32'(err_exp));
                holding = !resp_ready;
                if (resp_ready) begin
                    free    = 1'b1;
                    free_at = cyc + 1;
                end
            end else begin
                holding = 1'b0;
                if (q.size() > 0 && cyc > q[0].t) begin
                    check("resp_late", cyc, q[0].t);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        ord = '{0, 1, 2, 3};
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            a[i] = 0;
            b[i] = 0;
        end
        apply();
        repeat (3) @(negedge clk);
        #3;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_cmp_a", 32'(cmp_a), 0);
        check("rst_cmp_b", 32'(cmp_b), 0);
        check("rst_resp_id", 32'(resp_id), 0);
        check("rst_resp_res", 32'({resp_lt, resp_eq, resp_gt}), 0);
        check("rst_cmp_err", 32'(cmp_err), 0);

        // Single requester 0: 8 vs 9
        v[0] = 1'b1; a[0] = 8; b[0] = 9;
        step_drop();
        idle(4);

        // All valid, A=i, B=2, resp_ready tied high
        do_reset();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = i; b[i] = 2;
        end
        repeat (15) step();
        idle(4);

        // Boundary operand pairs
        v[1] = 1'b1; a[1] = 15; b[1] = 15;
        v[2] = 1'b1; a[2] = 0;  b[2] = 15;
        v[3] = 1'b1; a[3] = 12; b[3] = 3;
        repeat (10) step_drop();
        idle(3);

        // Back-pressure: resp_ready low while req1 waits
        v[0] = 1'b1; a[0] = 3; b[0] = 7;
        v[1] = 1'b1; a[1] = 9; b[1] = 9;
        rr = 1'b0;
        repeat (8) step_drop();
        rr = 1'b1;
        repeat (8) step_drop();
        idle(3);

        // Reset while requester 1 is in EVAL
        v[1] = 1'b1; a[1] = 4; b[1] = 6;
        step();
        v[3] = 1'b1; a[3] = 1; b[3] = 0;
        do_reset();
        repeat (8) step_drop();
        idle(3);

        // Illegal comparator verdict, then a clean op
        fault = 1'b1;
        v[2] = 1'b1; a[2] = 5; b[2] = 9;
        step_drop();
        idle(4);
        fault = 1'b0;
        v[3] = 1'b1; a[3] = 12; b[3] = 3;
        step_drop();
        idle(4);

        // Randomised traffic
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && last_acc && last_g == i) begin
                    v[i] = 1'($urandom_range(0, 1));
                    a[i] = int'($urandom_range(0, 15));
                    b[i] = int'($urandom_range(0, 15));
                end else if (v[i]) begin
                    if ($urandom_range(0, 7) == 0) v[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    v[i] = 1'b1;
                    a[i] = int'($urandom_range(0, 15));
                    b[i] = int'($urandom_range(0, 15));
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(8);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
